// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between fetch and
// the memory controller. Hits respond in one cycle, misses fill one word first.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [31:0] IF_addr,
    input  logic        IF_addr_sgn,
    output logic        IF_ins_sgn,
    output logic [31:0] IF_ins,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_done,
    input  logic [31:0] MC_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MISS, GAP} state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic [29:0]        miss_addr_q;
    logic               discard_q;
    logic               ins_sgn_q;
    logic [31:0]        ins_q;
    logic               mc_req_q;
    logic [31:0]        mc_addr_q;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      miss_tag;
    logic                  hit;
    logic                  fill;
    logic                  addr_match;
    logic                  unused_addr_bits;

    assign req_idx    = IF_addr[INDEX_BITS+1:2];
    assign req_tag    = IF_addr[31:INDEX_BITS+2];
    assign miss_idx   = miss_addr_q[INDEX_BITS-1:0];
    assign miss_tag   = miss_addr_q[29:INDEX_BITS];
    // Tag and data are read asynchronously so a hit answers in the next cycle.
    assign hit        = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill       = rdy && (state_q == MISS) && MC_done;
    assign addr_match = (IF_addr[31:2] == miss_addr_q);
    assign unused_addr_bits = ^IF_addr[1:0];

    assign IF_ins_sgn = ins_sgn_q;
    assign IF_ins     = ins_q;
    assign MC_req     = mc_req_q;
    assign MC_addr    = mc_addr_q;

    always_ff @(posedge clk) begin
        if (rst && fill) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= MC_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            discard_q   <= 1'b0;
            ins_sgn_q   <= 1'b0;
            ins_q       <= '0;
            mc_req_q    <= 1'b0;
            mc_addr_q   <= '0;
        end else if (!rdy) begin
            // Frozen; only the response pulse is withdrawn.
            ins_sgn_q <= 1'b0;
        end else begin
            ins_sgn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (IF_addr_sgn && !flush) begin
                        if (hit) begin
                            ins_sgn_q <= 1'b1;
                            ins_q     <= data_mem[req_idx];
                            state_q   <= GAP;
                        end else begin
                            miss_addr_q <= IF_addr[31:2];
                            mc_req_q    <= 1'b1;
                            mc_addr_q   <= {IF_addr[31:2], 2'b00};
                            state_q     <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (MC_done) begin
                        valid_q[miss_idx] <= 1'b1;
                        mc_req_q          <= 1'b0;
                        discard_q         <= 1'b0;
                        if (!discard_q && !flush && IF_addr_sgn && addr_match) begin
                            ins_sgn_q <= 1'b1;
                            ins_q     <= MC_data;
                            state_q   <= GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (flush) begin
                        discard_q <= 1'b1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
